// File: rtl/video_pkg.sv
// video_pkg: shared 640x480@60 raster constants and the coordinate type used by the
// timing generator and the downstream pattern stages.
package video_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b0;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef logic [CNT_W-1:0] coord_t;

endpackage

// File: rtl/video_timing_gen_wrap_counter.sv
// wrap_counter: modulo-MODULUS up-counter advancing on ce; wrap is high in the
// enabled cycle that returns the count to zero.
module wrap_counter #(
  parameter int unsigned MODULUS = 800,
  parameter int unsigned W       = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count and terminal-count wrap indication
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (ce) begin
      if (cnt_q == W'(MODULUS - 1)) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Count register; loads every cycle so the hold path comes from cnt_d
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: 640x480@60 raster timing (coordinates, DE, syncs, strobes).
// Optional 16-bit frame counter port enabled by defining VIDEO_TIMING_FRAME_CNT_EN.
module video_timing_gen
  import video_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   pix_ce,
  output coord_t x,
  output coord_t y,
  output logic   vde,
  output logic   hsync,
  output logic   vsync,
  output logic   line_start,
  output logic   frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  // Raster totals must fit the 10-bit counters
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end

  localparam coord_t H_ACT    = CNT_W'(H_ACTIVE);
  localparam coord_t V_ACT    = CNT_W'(V_ACTIVE);
  localparam coord_t HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  coord_t h_cnt, v_cnt;
  logic   h_wrap, v_wrap, v_ce;

  assign v_ce = pix_ce & h_wrap;

  wrap_counter #(.MODULUS(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .ce   (pix_ce),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  wrap_counter #(.MODULUS(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .ce   (v_ce),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  coord_t x_q, x_d, y_q, y_d;
  logic   vde_q, vde_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic   line_start_q, line_start_d, frame_start_q, frame_start_d;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

  // Decode the current counter position into the next output values
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    vde_d         = vde_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    frame_cnt_d   = frame_cnt_q;
`endif
    if (pix_ce) begin
      x_d           = h_cnt;
      y_d           = v_cnt;
      vde_d         = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hsync_d       = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
      vsync_d       = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      if ((h_cnt == '0) && (v_cnt == '0)) begin
        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      end
`endif
    end
  end

  // Output registers; reset presents the deasserted blanking state at (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      vde_q         <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      vde_q         <= vde_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign vde         = vde_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

  // v_wrap marks end of frame; frame_start is decoded from the counters instead
  logic unused_ok;
  assign unused_ok = v_wrap;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized and directed checks of video_timing_gen against a
// pixel-index reference model. Frame-counter checks are built when
// VIDEO_TIMING_FRAME_CNT_EN is defined.
module tb_video_timing_gen;

  localparam int H_TOT = 800;
  localparam int V_TOT = 525;
  localparam int F_TOT = H_TOT * V_TOT;

  logic       clk = 1'b0;
  logic       rst, pix_ce;
  logic [9:0] x, y;
  logic       vde, hsync, vsync, line_start, frame_start;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  video_timing_gen dut (
    .clk         (clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .x           (x),
    .y           (y),
    .vde         (vde),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Watchdog: end the run if something stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference model: a single pixel index walking the frame, decoded arithmetically
  int          p;
  logic [9:0]  ex, ey;
  logic        evde, ehs, evs, els, efs;
  logic [15:0] efc;

  task automatic model_clk(input bit r, input bit ce);
    int h, v;
    if (r) begin
      p = 0; ex = 0; ey = 0; evde = 0; ehs = 1; evs = 1; els = 0; efs = 0; efc = 0;
    end else if (ce) begin
      h    = p % H_TOT;
      v    = p / H_TOT;
      ex   = 10'(h);
      ey   = 10'(v);
      evde = (h < 640) && (v < 480);
      ehs  = !((h >= 656) && (h < 752));
      evs  = !((v >= 490) && (v < 492));
      els  = (h == 0);
      efs  = (p == 0);
      if (efs) efc = efc + 16'd1;
      p    = (p + 1) % F_TOT;
    end else begin
      els = 0;
      efs = 0;
    end
  endtask

  task automatic compare_all();
    check("x", 32'(x), 32'(ex));
    check("y", 32'(y), 32'(ey));
    check("vde", 32'(vde), 32'(evde));
    check("hsync", 32'(hsync), 32'(ehs));
    check("vsync", 32'(vsync), 32'(evs));
    check("line_start", 32'(line_start), 32'(els));
    check("frame_start", 32'(frame_start), 32'(efs));
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    check("frame_cnt", 32'(frame_cnt), 32'(efc));
`endif
  endtask

  int cyc_no = 0;

  task automatic cyc(input bit r, input bit ce);
    @(negedge clk);
    rst    = r;
    pix_ce = ce;
    @(posedge clk);
    model_clk(r, ce);
    cyc_no++;
    #1;
    compare_all();
  endtask

  // Move the vertical counter to line n with pix_ce low; the model follows
  task automatic jump_v(input logic [9:0] n);
    @(negedge clk);
    rst    = 0;
    pix_ce = 0;
    force dut.u_v_cnt.cnt_q = n;
    @(posedge clk);
    model_clk(0, 0);
    cyc_no++;
    #1;
    release dut.u_v_cnt.cnt_q;
    p = int'(n) * H_TOT + (p % H_TOT);
    compare_all();
  endtask

  int last_ls, vde_n, hs_n, vs_n, fs_n;

  // mode 0: pix_ce high, 1: random, 2: one cycle in four
  task automatic run(input int n, input int mode, input int exp_period);
    last_ls = -1; vde_n = 0; hs_n = 0;
    for (int i = 0; i < n; i++) begin
      bit ce;
      case (mode)
        0:       ce = 1'b1;
        1:       ce = 1'($urandom_range(0, 1));
        default: ce = (i % 4 == 0);
      endcase
      cyc(0, ce);
      if (!vsync) vs_n++;
      if (frame_start) fs_n++;
      if (line_start) begin
        if (exp_period != 0 && last_ls >= 0) begin
          check("line_period", 32'(cyc_no - last_ls), 32'(exp_period));
          check("vde_per_line", 32'(vde_n), 32'(640 * (exp_period / H_TOT)));
          check("hsync_per_line", 32'(hs_n), 32'(96 * (exp_period / H_TOT)));
        end
        last_ls = cyc_no; vde_n = 0; hs_n = 0;
      end
      if (vde) vde_n++;
      if (!hsync) hs_n++;
    end
  endtask

  // Run with pix_ce high until frame_start, bounded
  task automatic run_to_fs(input string tag);
    bit hit = 0;
    for (int i = 0; i < 1700 && !hit; i++) begin
      cyc(0, 1);
      hit = frame_start;
    end
    if (!hit) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    bit hit;
    rst = 1; pix_ce = 0;
    p = 0; ex = 0; ey = 0; evde = 0; ehs = 1; evs = 1; els = 0; efs = 0; efc = 0;

    // Reset sanity
    for (int i = 0; i < 5; i++) cyc(1, 1);
    check("rst_x", 32'(x), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_vde", 32'(vde), 32'd0);

    // First enabled cycle presents (0,0) with both strobes
    cyc(0, 1);
    check("first_vde", 32'(vde), 32'd1);
    check("first_fs", 32'(frame_start), 32'd1);
    check("first_ls", 32'(line_start), 32'd1);

    // Line timing with pix_ce tied high
    run(1700, 0, 800);
    // Random enable
    run(2000, 1, 0);
    // One-in-four enable
    run(7000, 2, 3200);

    // Vertical sync region
    jump_v(10'd488);
    vs_n = 0;
    run(4800, 0, 0);
    check("vsync_width", 32'(vs_n), 32'd1600);

    // Frame wrap
    jump_v(10'd524);
    fs_n = 0;
    run(1600, 0, 0);
    check("frame_start_count", 32'(fs_n), 32'd1);

    // Mid-frame reset at (300,200)
    cyc(1, 0);
    jump_v(10'd200);
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      cyc(0, 1);
      hit = (x == 10'd300) && (y == 10'd200);
    end
    check("reach_300_200", 32'(hit), 32'd1);
    cyc(1, 1);
    check("mid_rst_x", 32'(x), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_vde", 32'(vde), 32'd0);
    check("mid_rst_hsync", 32'(hsync), 32'd1);
    check("mid_rst_vsync", 32'(vsync), 32'd1);
    cyc(0, 0);
    check("hold_fs", 32'(frame_start), 32'd0);
    cyc(0, 1);
    check("restart_x", 32'(x), 32'd0);
    check("restart_y", 32'(y), 32'd0);
    check("restart_fs", 32'(frame_start), 32'd1);

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    check("fcnt_1", 32'(frame_cnt), 32'd1);
    jump_v(10'd524);
    run_to_fs("fs_reach_2");
    check("fcnt_2", 32'(frame_cnt), 32'd2);
    jump_v(10'd524);
    run_to_fs("fs_reach_3");
    check("fcnt_3", 32'(frame_cnt), 32'd3);
    // Preload the frame counter to its top value
    @(negedge clk);
    pix_ce = 0;
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk);
    model_clk(0, 0);
    #1;
    release dut.frame_cnt_q;
    efc = 16'hFFFF;
    jump_v(10'd524);
    run_to_fs("fs_reach_wrap");
    check("fcnt_wrap", 32'(frame_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
